// File: rtl/tdc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tdc_pkg : shared state encoding, defaults and width helper for the TDC
// Revision: 1.0
// ---------------------------------------------------------------------------
package tdc_pkg;

  localparam int DEF_TAPS     = 64;
  localparam int DEF_COARSE_W = 16;
  localparam int DEF_HOLDOFF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } tdc_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tdc_capture_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tdc_capture_ctrl_if : arm/tap inputs and result valid/ready port
// Revision: 1.0
// ---------------------------------------------------------------------------
interface tdc_capture_ctrl_if
  import tdc_pkg::*;
#(
  parameter int TAPS     = DEF_TAPS,
  parameter int COARSE_W = DEF_COARSE_W
) ();

  localparam int FW = clog2(TAPS + 1);

  logic                arm;
  logic [TAPS-1:0]     taps_q;
  logic                busy;
  logic                arm_err;
  logic                result_valid;
  logic                result_ready;
  logic [COARSE_W-1:0] result_coarse;
  logic [FW-1:0]       result_fine;
  logic                result_overflow;
  logic                result_bubble;

  // Slave is the capture controller; master is the sampler/readout side.
  modport slave (
    input  arm, taps_q, result_ready,
    output busy, arm_err, result_valid, result_coarse, result_fine,
           result_overflow, result_bubble
  );

  modport master (
    output arm, taps_q, result_ready,
    input  busy, arm_err, result_valid, result_coarse, result_fine,
           result_overflow, result_bubble
  );

endinterface
`default_nettype wire

// File: rtl/tdc_therm_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tdc_therm_encoder : popcount of the tap sample plus thermometer-shape check
// Revision: 1.0
// ---------------------------------------------------------------------------
module tdc_therm_encoder
  import tdc_pkg::*;
#(
  parameter int TAPS = DEF_TAPS
) (
  input  logic [TAPS-1:0]            taps,
  output logic [clog2(TAPS+1)-1:0]   fine,
  output logic                       bubble,
  output logic                       nonzero
);

  localparam int FW = clog2(TAPS + 1);

  logic [FW-1:0]   count;
  logic [TAPS-1:0] ideal;

  // A clean code has exactly `count` ones packed against bit 0.
  always_comb begin
    count = '0;
    ideal = '0;
    for (int i = 0; i < TAPS; i++) count = count + FW'(taps[i]);
    for (int i = 0; i < TAPS; i++) ideal[i] = (FW'(i) < count);
  end

  assign fine    = count;
  assign bubble  = (taps != ideal);
  assign nonzero = |taps;

endmodule
`default_nettype wire

// File: rtl/tdc_capture_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tdc_capture_ctrl : arms a coarse counter, captures first non-zero tap
// sample as {coarse, fine, flags}, then waits for the line to drain.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tdc_capture_ctrl
  import tdc_pkg::*;
#(
  parameter int TAPS     = DEF_TAPS,
  parameter int COARSE_W = DEF_COARSE_W,
  parameter int HOLDOFF  = DEF_HOLDOFF
) (
  input  logic               clk,
  input  logic               rst_n,
  tdc_capture_ctrl_if.slave  bus
);

  localparam int FW = clog2(TAPS + 1);
  localparam int HW = clog2(HOLDOFF + 1);
  localparam logic [COARSE_W-1:0] CNT_MAX = {COARSE_W{1'b1}};

  tdc_state_e          state_q, state_d;
  logic [COARSE_W-1:0] cnt_q, cnt_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [COARSE_W-1:0] coarse_q, coarse_d;
  logic [FW-1:0]       fine_q, fine_d;
  logic                ovf_q, ovf_d;
  logic                bubble_q, bubble_d;
  logic                arm_err_q, arm_err_d;

  logic [FW-1:0]       enc_fine;
  logic                enc_bubble;
  logic                enc_nonzero;

  tdc_therm_encoder #(.TAPS(TAPS)) u_enc (
    .taps    (bus.taps_q),
    .fine    (enc_fine),
    .bubble  (enc_bubble),
    .nonzero (enc_nonzero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      coarse_q  <= '0;
      fine_q    <= '0;
      ovf_q     <= 1'b0;
      bubble_q  <= 1'b0;
      arm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      coarse_q  <= coarse_d;
      fine_q    <= fine_d;
      ovf_q     <= ovf_d;
      bubble_q  <= bubble_d;
      arm_err_q <= arm_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    coarse_d  = coarse_q;
    fine_d    = fine_q;
    ovf_d     = ovf_q;
    bubble_d  = bubble_q;
    // An arm is only honoured from IDLE with a quiet delay line.
    arm_err_d = bus.arm && ((state_q != ST_IDLE) || enc_nonzero);

    case (state_q)
      ST_IDLE: begin
        if (bus.arm && !enc_nonzero) begin
          state_d = ST_ARMED;
          cnt_d   = '0;
        end
      end
      ST_ARMED: begin
        if (enc_nonzero) begin
          coarse_d = cnt_q;
          fine_d   = enc_fine;
          bubble_d = enc_bubble;
          ovf_d    = 1'b0;
          state_d  = ST_DONE;
        end else if (cnt_q == CNT_MAX) begin
          coarse_d = CNT_MAX;
          fine_d   = '0;
          bubble_d = 1'b0;
          ovf_d    = 1'b1;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.result_ready) begin
          state_d = ST_DRAIN;
          hold_d  = '0;
        end
      end
      ST_DRAIN: begin
        if (enc_nonzero) begin
          hold_d = '0;
        end else if (hold_q == HW'(HOLDOFF - 1)) begin
          hold_d  = '0;
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy            = (state_q != ST_IDLE);
  assign bus.arm_err         = arm_err_q;
  assign bus.result_valid    = (state_q == ST_DONE);
  assign bus.result_coarse   = coarse_q;
  assign bus.result_fine     = fine_q;
  assign bus.result_overflow = ovf_q;
  assign bus.result_bubble   = bubble_q;

endmodule
`default_nettype wire
